dionysus_sdram_arbiter: RTL

Shares the single SDRAM command/address bus between the write path, the read path and periodic auto-refresh once the init sequence is complete. Grants the bus to exactly one owner at a time using round-robin between reader and writer. Schedules auto-refresh from an internal timer and asks the current owner to yield. Runs in the SDRAM clock domain and sits between the read/write path engines and the pad-level command outputs.

---
 rtl/dionysus_sdram_arbiter.sv | 284 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/dionysus_sdram_arbiter.sv
// dionysus_sdram_arbiter
// Shares the SDRAM command/address bus between the write path, the read path
// and periodic auto-refresh once initialisation has finished. Reader and
// writer are served round-robin; refresh asks the current owner to yield.
// Optional build macro: SDRAM_ARB_STATS_EN adds refresh statistics outputs.
module dionysus_sdram_arbiter #(
  parameter logic [15:0] AR_TIMEOUT = 16'd1500,
  parameter logic [7:0]  T_RFC      = 8'd7,
  parameter logic [15:0] MAX_GRANT  = 16'd256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        init_done,
  input  logic        wr_req,
  input  logic        wr_release,
  output logic        wr_grant,
  input  logic [2:0]  wr_command,
  input  logic [11:0] wr_address,
  input  logic [1:0]  wr_bank,
  input  logic        rd_req,
  input  logic        rd_release,
  output logic        rd_grant,
  input  logic [2:0]  rd_command,
  input  logic [11:0] rd_address,
  input  logic [1:0]  rd_bank,
  output logic        yield,
  output logic [2:0]  command,
  output logic [11:0] address,
  output logic [1:0]  bank,
  output logic        data_oe,
  output logic        busy
`ifdef SDRAM_ARB_STATS_EN
  ,
  output logic [15:0] refresh_total,
  output logic [15:0] refresh_latency_max
`endif
);

  localparam logic [2:0] ST_INIT      = 3'd0;
  localparam logic [2:0] ST_IDLE      = 3'd1;
  localparam logic [2:0] ST_WR        = 3'd2;
  localparam logic [2:0] ST_RD        = 3'd3;
  localparam logic [2:0] ST_REF_ISSUE = 3'd4;
  localparam logic [2:0] ST_REF_WAIT  = 3'd5;

  localparam logic [2:0] CMD_NOP = 3'b111;
  localparam logic [2:0] CMD_AR  = 3'b001;

  logic [2:0]  state_r;
  logic [2:0]  state_next_s;
  logic        last_owner_r;   // 1 = write path owned last, 0 = read path
  logic [15:0] timer_r;
  logic        pending_r;
  logic [7:0]  rfc_cnt_r;
  logic [15:0] grant_cnt_r;    // owned cycles so far, including the current one
  logic        owned_s;
  logic        other_req_s;

  assign owned_s = (state_r == ST_WR) || (state_r == ST_RD);

  // Next-state selection; refresh beats requests, ties go to the side not served last
  always_comb begin
    state_next_s = state_r;
    if (!init_done) begin
      state_next_s = ST_INIT;
    end else begin
      case (state_r)
        ST_INIT: state_next_s = ST_IDLE;
        ST_IDLE: begin
          if (pending_r) begin
            state_next_s = ST_REF_ISSUE;
          end else if (wr_req && (!rd_req || !last_owner_r)) begin
            state_next_s = ST_WR;
          end else if (rd_req) begin
            state_next_s = ST_RD;
          end else begin
            state_next_s = ST_IDLE;
          end
        end
        ST_WR: begin
          if (wr_release) begin
            state_next_s = ST_IDLE;
          end else begin
            state_next_s = ST_WR;
          end
        end
        ST_RD: begin
          if (rd_release) begin
            state_next_s = ST_IDLE;
          end else begin
            state_next_s = ST_RD;
          end
        end
        ST_REF_ISSUE: state_next_s = ST_REF_WAIT;
        ST_REF_WAIT: begin
          if (rfc_cnt_r == 8'd0) begin
            state_next_s = ST_IDLE;
          end else begin
            state_next_s = ST_REF_WAIT;
          end
        end
        default: state_next_s = ST_INIT;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_INIT;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Remember who released last so the other side wins the next tie
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_owner_r <= 1'b0;
    end else if ((state_r == ST_WR) && (state_next_s == ST_IDLE)) begin
      last_owner_r <= 1'b1;
    end else if ((state_r == ST_RD) && (state_next_s == ST_IDLE)) begin
      last_owner_r <= 1'b0;
    end else begin
      last_owner_r <= last_owner_r;
    end
  end

  // tRFC countdown, loaded while the AR command is on the bus
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rfc_cnt_r <= 8'd0;
    end else if (state_r == ST_REF_ISSUE) begin
      rfc_cnt_r <= T_RFC - 8'd1;
    end else if ((state_r == ST_REF_WAIT) && (rfc_cnt_r != 8'd0)) begin
      rfc_cnt_r <= rfc_cnt_r - 8'd1;
    end else begin
      rfc_cnt_r <= rfc_cnt_r;
    end
  end

  // Refresh timer and sticky pending flag; frozen in INIT and during refresh
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timer_r   <= AR_TIMEOUT;
      pending_r <= 1'b0;
    end else if (!init_done) begin
      timer_r   <= AR_TIMEOUT;
      pending_r <= 1'b0;
    end else if ((state_r == ST_REF_WAIT) && (rfc_cnt_r == 8'd0)) begin
      timer_r   <= AR_TIMEOUT;
      pending_r <= 1'b0;
    end else if ((state_r == ST_IDLE) || owned_s) begin
      // Pending rises together with the timer reaching zero
      if (timer_r <= 16'd1) begin
        pending_r <= 1'b1;
      end else begin
        pending_r <= pending_r;
      end
      if (timer_r != 16'd0) begin
        timer_r <= timer_r - 16'd1;
      end else begin
        timer_r <= timer_r;
      end
    end else begin
      timer_r   <= timer_r;
      pending_r <= pending_r;
    end
  end

  // Owned-cycle counter; primed in IDLE so the first owned cycle counts as one
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant_cnt_r <= 16'd0;
    end else if (state_r == ST_IDLE) begin
      grant_cnt_r <= 16'd1;
    end else if (owned_s) begin
      if (grant_cnt_r != MAX_GRANT) begin
        grant_cnt_r <= grant_cnt_r + 16'd1;
      end else begin
        grant_cnt_r <= grant_cnt_r;
      end
    end else begin
      grant_cnt_r <= 16'd0;
    end
  end

  assign wr_grant = (state_r == ST_WR);
  assign rd_grant = (state_r == ST_RD);
  assign data_oe  = wr_grant;
  assign busy     = (state_r != ST_IDLE) && (state_r != ST_INIT);

  // Yield request towards the current owner only
  always_comb begin
    other_req_s = 1'b0;
    yield       = 1'b0;
    if (state_r == ST_WR) begin
      other_req_s = rd_req;
    end else begin
      other_req_s = wr_req;
    end
    if (owned_s) begin
      yield = pending_r || ((grant_cnt_r == MAX_GRANT) && other_req_s);
    end else begin
      yield = 1'b0;
    end
  end

  // Pad command mux: zero-latency pass-through of the owner, AR or NOP otherwise
  always_comb begin
    command = CMD_NOP;
    address = 12'd0;
    bank    = 2'd0;
    case (state_r)
      ST_WR: begin
        command = wr_command;
        address = wr_address;
        bank    = wr_bank;
      end
      ST_RD: begin
        command = rd_command;
        address = rd_address;
        bank    = rd_bank;
      end
      ST_REF_ISSUE: begin
        command = CMD_AR;
        address = 12'd0;
        bank    = 2'd0;
      end
      default: begin
        command = CMD_NOP;
        address = 12'd0;
        bank    = 2'd0;
      end
    endcase
  end

`ifdef SDRAM_ARB_STATS_EN
  logic [15:0] total_r;
  logic [15:0] lat_r;
  logic [15:0] lat_max_r;

  // Refresh statistics: AR count and worst pending-to-issue latency
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      total_r   <= 16'd0;
      lat_r     <= 16'd0;
      lat_max_r <= 16'd0;
    end else if (!init_done) begin
      total_r   <= 16'd0;
      lat_r     <= 16'd0;
      lat_max_r <= 16'd0;
    end else begin
      if (!pending_r) begin
        lat_r <= 16'd0;
      end else if ((state_r != ST_REF_ISSUE) && (state_r != ST_REF_WAIT) &&
                   (lat_r != 16'hFFFF)) begin
        lat_r <= lat_r + 16'd1;
      end else begin
        lat_r <= lat_r;
      end
      if (state_r == ST_REF_ISSUE) begin
        if (total_r != 16'hFFFF) begin
          total_r <= total_r + 16'd1;
        end else begin
          total_r <= total_r;
        end
        if (lat_r > lat_max_r) begin
          lat_max_r <= lat_r;
        end else begin
          lat_max_r <= lat_max_r;
        end
      end else begin
        total_r   <= total_r;
        lat_max_r <= lat_max_r;
      end
    end
  end

  assign refresh_total       = total_r;
  assign refresh_latency_max = lat_max_r;
`endif

endmodule
